// File: rtl/s1_ctrl_pkg.sv
// Shared definitions for the S1 sequencer: state encoding, control-word field
// positions and the pc_sel / wb_sel mux encodings (also imported by the decode ROM).
package s1_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam int CW_WB_SEL_HI    = 11;
    localparam int CW_WB_SEL_LO    = 10;
    localparam int CW_RF_WE        = 9;
    localparam int CW_MEM_RD       = 8;
    localparam int CW_MEM_WR       = 7;
    localparam int CW_JMP_HI       = 6;
    localparam int CW_JMP_LO       = 5;
    localparam int CW_COND_JMP     = 4;
    localparam int CW_LINK         = 3;
    localparam int CW_MEM_ADDR_IMM = 2;
    localparam int CW_STORE_DATA   = 1;
    localparam int CW_ALU_IMM      = 0;

    typedef enum logic [1:0] {
        PC_SEL_INC  = 2'b00,
        PC_SEL_JAL  = 2'b01,
        PC_SEL_JALR = 2'b10,
        PC_SEL_BR   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LUI  = 2'b01,
        WB_SEL_LOAD = 2'b10,
        WB_SEL_LINK = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/s1_bus_timer.sv
// Bus acknowledge watchdog: counts cycles while a request is outstanding and
// flags the cycle in which the count would reach ACK_TIMEOUT (0 disables it).
module s1_bus_timer #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !start) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the request cycles already spent, so the current one is the last allowed
    assign expired = start && (ACK_TIMEOUT != 0) && (cnt_q == TMO_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/s1_seq_ctrl.sv
// S1 multi-cycle sequencer: walks fetch/decode/execute/memory/writeback from the
// decoded control word and owns the shared bus port and all write strobes.
//   state  | meaning
//   FETCH  | request instruction at PC, load IR on ack
//   DECODE | control word settling, no strobes
//   EXEC   | ALU op; jumps and branches retire here
//   MEM    | data load/store on the bus; stores retire here
//   WB     | register write-back and PC+1, retire
//   HALT   | parked at an instruction boundary while halt_req
//   FAULT  | bus ack timeout, left only through reset
module s1_seq_ctrl
    import s1_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt_req,
    input  logic [11:0] ctrl_word,
    input  logic        cond_true,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_fetch,
    input  logic        bus_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_imm,
    output logic        retire,
    output logic        halted,
    output logic        fault
);

    state_e state_q, state_d;
    logic   run_q, run_d;
    logic   tmr_expired;
    logic   tmr_clear;

    logic       cw_mem_rd, cw_mem_wr, cw_cond, cw_link;
    logic [1:0] cw_jmp_sel;
    logic       unused_ctrl;

    assign cw_mem_rd   = ctrl_word[CW_MEM_RD];
    assign cw_mem_wr   = ctrl_word[CW_MEM_WR];
    assign cw_cond     = ctrl_word[CW_COND_JMP];
    assign cw_link     = ctrl_word[CW_LINK];
    assign cw_jmp_sel  = ctrl_word[CW_JMP_HI:CW_JMP_LO];
    assign unused_ctrl = ^{ctrl_word[CW_MEM_ADDR_IMM], ctrl_word[CW_STORE_DATA]};

    // run_q keeps every output quiet for the first cycle out of reset
    assign run_d = 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_fetch = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_INC;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        alu_imm   = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;

        if (run_q) begin
            unique case (state_q)
                ST_FETCH: begin
                    bus_req   = 1'b1;
                    bus_fetch = 1'b1;
                    if (bus_ack) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (tmr_expired) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    alu_imm = ctrl_word[CW_ALU_IMM];
                    if (cw_mem_rd || cw_mem_wr) begin
                        state_d = ST_MEM;
                    end else if (cw_jmp_sel != 2'b00) begin
                        pc_we  = 1'b1;
                        pc_sel = cw_jmp_sel;
                        if (cw_link) begin
                            rf_we  = 1'b1;
                            wb_sel = WB_SEL_LINK;
                        end
                        retire = 1'b1;
                    end else if (cw_cond) begin
                        pc_we  = 1'b1;
                        pc_sel = cond_true ? PC_SEL_BR : PC_SEL_INC;
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    bus_req = 1'b1;
                    bus_we  = cw_mem_wr;
                    if (bus_ack) begin
                        if (cw_mem_wr) begin
                            pc_we  = 1'b1;
                            retire = 1'b1;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (tmr_expired) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_WB: begin
                    rf_we  = ctrl_word[CW_RF_WE];
                    wb_sel = ctrl_word[CW_WB_SEL_HI:CW_WB_SEL_LO];
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (!halt_req) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase

            if (retire) begin
                state_d = halt_req ? ST_HALT : ST_FETCH;
            end
        end
    end

    assign tmr_clear = bus_ack || (state_d != state_q);

    s1_bus_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_bus_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bus_req),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

endmodule

// File: tb/tb_s1_seq_ctrl.sv
// Bench for s1_seq_ctrl: directed instruction table, hand-written reset/fault
// sequences and randomized instructions checked against an instruction-level model.
module tb_s1_seq_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n, halt_req, cond_true, bus_ack;
    logic [11:0] ctrl_word;
    logic        bus_req, bus_we, bus_fetch, ir_we, pc_we, rf_we, alu_imm, retire, halted, fault;
    logic [1:0]  pc_sel, wb_sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    s1_seq_ctrl #(.ACK_TIMEOUT(T), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .ctrl_word(ctrl_word),
        .cond_true(cond_true), .bus_req(bus_req), .bus_we(bus_we), .bus_fetch(bus_fetch),
        .bus_ack(bus_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_imm(alu_imm), .retire(retire), .halted(halted), .fault(fault)
    );

    typedef struct packed {
        logic       bus_req, bus_we, bus_fetch, ir_we, pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_imm, retire, halted, fault;
    } outs_t;

    typedef struct {
        logic        ack, halt, cond, rst;
        logic [11:0] ctrl;
        outs_t       exp;
    } cyc_t;

    typedef struct {
        logic [11:0] cw;
        logic        c;
        int          fw, dw;
        int          cyc;
        logic [1:0]  ps;
        int          rf;
        logic [1:0]  wb;
        logic        we;
    } vec_t;

    cyc_t q[$];

    function automatic outs_t cur();
        return {bus_req, bus_we, bus_fetch, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                alu_imm, retire, halted, fault};
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic ack, input logic halt, input logic cond,
                         input logic [11:0] ctrl, input logic rst);
        @(negedge clk);
        bus_ack   = ack;
        halt_req  = halt;
        cond_true = cond;
        ctrl_word = ctrl;
        rst_n     = !rst;
        #1;
    endtask

    task automatic push(input logic ack, input logic halt, input logic cond, input logic rst,
                        input logic [11:0] ctrl, input outs_t e);
        cyc_t c;
        c.ack = ack; c.halt = halt; c.cond = cond; c.rst = rst; c.ctrl = ctrl; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_wb(input logic [11:0] cw, input logic h);
        outs_t o;
        o = '0;
        o.rf_we  = cw[9];
        o.wb_sel = cw[11:10];
        o.pc_we  = 1'b1;
        o.retire = 1'b1;
        push(rbit(), h, rbit(), 1'b0, cw, o);
    endtask

    // Instruction-level model: expected per-cycle outputs from the instruction class,
    // the bus wait counts and the halt behaviour.
    task automatic model_instr(input logic [11:0] cw, input logic c, input int fw,
                               input int dw, input int hmode, input int hlen);
        outs_t o;
        logic  h;
        bit    fl;
        int    n;
        fl = 0;
        h  = (hmode == 2);
        n  = (fw < T) ? fw + 1 : T;
        for (int i = 0; i < n; i++) begin
            o = '0; o.bus_req = 1'b1; o.bus_fetch = 1'b1; o.ir_we = (i == fw);
            push(i == fw, 1'b0, rbit(), 1'b0, 12'($urandom), o);
        end
        if (fw >= T) fl = 1;
        if (!fl) begin
            o = '0;
            push(rbit(), hmode == 1, rbit(), 1'b0, cw, o);
            o = '0; o.alu_imm = cw[0];
            if (cw[8] || cw[7]) begin
                push(rbit(), h, c, 1'b0, cw, o);
                n = (dw < T) ? dw + 1 : T;
                for (int i = 0; i < n; i++) begin
                    o = '0; o.bus_req = 1'b1; o.bus_we = cw[7];
                    if (i == dw && cw[7]) begin o.pc_we = 1'b1; o.retire = 1'b1; end
                    push(i == dw, h, rbit(), 1'b0, cw, o);
                end
                if (dw >= T) fl = 1;
                else if (!cw[7]) push_wb(cw, h);
            end else if (cw[6:5] != 2'b00) begin
                o.pc_we = 1'b1; o.pc_sel = cw[6:5]; o.retire = 1'b1;
                if (cw[3]) begin o.rf_we = 1'b1; o.wb_sel = 2'b11; end
                push(rbit(), h, c, 1'b0, cw, o);
            end else if (cw[4]) begin
                o.pc_we = 1'b1; o.pc_sel = c ? 2'b11 : 2'b00; o.retire = 1'b1;
                push(rbit(), h, c, 1'b0, cw, o);
            end else begin
                push(rbit(), h, c, 1'b0, cw, o);
                push_wb(cw, h);
            end
        end
        if (fl) begin
            o = '0; o.fault = 1'b1;
            for (int i = 0; i < 3; i++) push(rbit(), rbit(), rbit(), 1'b0, 12'($urandom), o);
            push(1'b0, 1'b0, 1'b0, 1'b1, cw, o);
            o = '0;
            push(rbit(), rbit(), rbit(), 1'b0, cw, o);
        end else if (h) begin
            o = '0; o.halted = 1'b1;
            for (int i = 0; i < hlen; i++) push(rbit(), 1'b1, rbit(), 1'b0, cw, o);
            push(rbit(), 1'b0, rbit(), 1'b0, cw, o);
        end
    endtask

    // Reactive driver: acks each bus phase after the requested wait, records what retired.
    task automatic run_vec(input vec_t v, output int cyc, output logic [1:0] ps,
                           output int rfn, output logic [1:0] wb, output logic we);
        int rq;
        bit done;
        cyc = 0; ps = 2'b00; rfn = 0; wb = 2'b00; we = 1'b0; rq = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            ctrl_word = v.cw; cond_true = v.c; halt_req = 1'b0; bus_ack = 1'b0; rst_n = 1'b1;
            #1;
            if (bus_req) begin
                bus_ack = (rq == (bus_fetch ? v.fw : v.dw));
                rq = bus_ack ? 0 : rq + 1;
            end
            #1;
            cyc++;
            if (bus_we) we = 1'b1;
            if (rf_we) begin rfn++; wb = wb_sel; end
            if (retire) begin ps = pc_sel; done = 1; end
        end
    endtask

    initial begin
        vec_t  vt[9];
        int    cyc, rfn;
        logic [1:0] ps, wb;
        logic  we;
        outs_t o;
        cyc_t  e;

        vt[0] = '{12'h200, 1'b0, 0, 0, 4, 2'b00, 1, 2'b00, 1'b0};
        vt[1] = '{12'hB25, 1'b0, 0, 3, 8, 2'b00, 1, 2'b10, 1'b0};
        vt[2] = '{12'h087, 1'b0, 0, 0, 4, 2'b00, 0, 2'b00, 1'b1};
        vt[3] = '{12'h028, 1'b0, 0, 0, 3, 2'b01, 1, 2'b11, 1'b0};
        vt[4] = '{12'h010, 1'b1, 0, 0, 3, 2'b11, 0, 2'b00, 1'b0};
        vt[5] = '{12'h010, 1'b0, 0, 0, 3, 2'b00, 0, 2'b00, 1'b0};
        vt[6] = '{12'h201, 1'b0, 3, 0, 7, 2'b00, 1, 2'b00, 1'b0};
        vt[7] = '{12'h601, 1'b0, 1, 0, 5, 2'b00, 1, 2'b01, 1'b0};
        vt[8] = '{12'h040, 1'b0, 0, 0, 3, 2'b10, 0, 2'b00, 1'b0};

        rst_n = 1'b0; halt_req = 1'b0; cond_true = 1'b0; bus_ack = 1'b0; ctrl_word = '0;

        apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        check("reset_outputs", 32'(cur()), 32'd0);
        apply(1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0);
        check("first_cycle_quiet", 32'(cur()), 32'd0);

        foreach (vt[i]) begin
            run_vec(vt[i], cyc, ps, rfn, wb, we);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
            check($sformatf("vec%0d_pc_sel", i), 32'(ps), 32'(vt[i].ps));
            check($sformatf("vec%0d_rf_count", i), 32'(rfn), 32'(vt[i].rf));
            check($sformatf("vec%0d_wb_sel", i), 32'(wb), 32'(vt[i].wb));
            check($sformatf("vec%0d_bus_we", i), 32'(we), 32'(vt[i].we));
        end

        // reset while a store waits in MEM
        apply(1'b1, 1'b0, 1'b0, 12'h087, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 12'h087, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 12'h087, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 12'h087, 1'b0);
        o = '0; o.bus_req = 1'b1; o.bus_we = 1'b1;
        check("store_mem_wait", 32'(cur()), 32'(o));
        apply(1'b0, 1'b0, 1'b0, 12'h087, 1'b1);
        check("store_mem_in_reset", 32'(cur()), 32'(o));
        apply(1'b1, 1'b0, 1'b0, 12'h087, 1'b1);
        check("after_reset_mid_mem", 32'(cur()), 32'd0);
        apply(1'b1, 1'b0, 1'b0, 12'h087, 1'b0);
        check("release_quiet", 32'(cur()), 32'd0);

        // fetch never acked: four request cycles, then sticky fault
        o = '0; o.bus_req = 1'b1; o.bus_fetch = 1'b1;
        for (int i = 0; i < T; i++) begin
            apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
            check($sformatf("tmo_req%0d", i), 32'(cur()), 32'(o));
        end
        o = '0; o.fault = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(rbit(), rbit(), rbit(), 12'($urandom), 1'b0);
            check($sformatf("fault_hold%0d", i), 32'(cur()), 32'(o));
        end
        apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        check("fault_cleared", 32'(cur()), 32'd0);

        for (int k = 0; k < 300; k++) begin
            model_instr(12'($urandom), rbit(),
                        ($urandom_range(0, 15) == 0) ? T + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3)),
                        ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            while (q.size() > 0) begin
                e = q.pop_front();
                apply(e.ack, e.halt, e.cond, e.ctrl, e.rst);
                check($sformatf("rand_instr%0d", k), 32'(cur()), 32'(e.exp));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
